alu_wb_buffer: RTL

Result buffer directly downstream of the ALU functional unit.
- Captures each ALU result together with its transaction ID and branch-compare bit.
- Presents results in order to the scoreboard writeback port over a valid/ready handshake.
- Decouples ALU issue from writeback-port arbitration, so the ALU does not stall while the writeback port is granted to another functional unit.

---
 rtl/alu_wb_buffer.sv | 64 ++++++
 1 files changed

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: in-order result FIFO between the ALU and the scoreboard writeback port
module alu_wb_buffer #(
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [XLEN-1:0]              alu_result_i,
  input  logic [TRANS_ID_BITS-1:0]     alu_trans_id_i,
  input  logic                         alu_branch_res_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [XLEN-1:0]              wb_result_o,
  output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
  output logic                         wb_branch_res_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     branch_res;
  } entry_t;
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign alu_ready_o     = count != CW'(DEPTH);
  assign wb_valid_o      = count != '0;
  assign push            = alu_valid_i && alu_ready_o;
  assign pop             = wb_valid_o && wb_ready_i;
  assign wb_result_o     = mem[rd_ptr].result;
  assign wb_trans_id_o   = mem[rd_ptr].trans_id;
  assign wb_branch_res_o = mem[rd_ptr].branch_res;
  assign count_o         = count;
  // flush clears only the bookkeeping; stale storage is hidden by count == 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{alu_result_i, alu_trans_id_i, alu_branch_res_i};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
